// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the pipelined MIPS datapath.
// It carries the decoded control word, operands and register indices from
// decode into execute. It inserts a bubble when the decode instruction is
// flushed, or when that instruction depends on a load that is now in EX.
// It holds everything while the pipeline is stalled, and it keeps a
// saturating count of the bubbles it has inserted.
//
// Build option: define ID_EX_HAZARD_EN to build load-use detection. When
// the macro is undefined, hazard_stall_o is tied low and only flush
// bubbles are inserted and counted.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              reg_dst_i,
  input  logic              branch_i,
  input  logic              mem_to_reg_i,
  input  logic              alu_src_i,
  input  logic              reg_write_i,
  input  logic [1:0]        jump_i,
  input  logic [1:0]        mem_read_i,
  input  logic [1:0]        mem_write_i,
  input  logic [3:0]        alu_op_i,
  input  logic [DATA_W-1:0] pc4_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [RA_W-1:0]   rs_i,
  input  logic [RA_W-1:0]   rt_i,
  input  logic [RA_W-1:0]   rd_i,
  input  logic [5:0]        funct_i,
  output logic              reg_dst_o,
  output logic              branch_o,
  output logic              mem_to_reg_o,
  output logic              alu_src_o,
  output logic              reg_write_o,
  output logic [1:0]        jump_o,
  output logic [1:0]        mem_read_o,
  output logic [1:0]        mem_write_o,
  output logic [3:0]        alu_op_o,
  output logic [DATA_W-1:0] pc4_o,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [RA_W-1:0]   rs_o,
  output logic [RA_W-1:0]   rt_o,
  output logic [RA_W-1:0]   rd_o,
  output logic [5:0]        funct_o,
  output logic              valid_o,
  output logic              hazard_stall_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  // Control word: every field is cleared in a bubble.
  typedef struct packed {
    logic       reg_dst;
    logic       branch;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] jump;
    logic [1:0] mem_read;
    logic [1:0] mem_write;
    logic [3:0] alu_op;
  } ctrl_t;

  // Data word: every field is kept unchanged in a bubble.
  typedef struct packed {
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [RA_W-1:0]   rs;
    logic [RA_W-1:0]   rt;
    logic [RA_W-1:0]   rd;
    logic [5:0]        funct;
  } data_t;

  // Update applied to the register on the next edge (reset is handled separately).
  typedef enum logic [1:0] {
    ACT_HOLD    = 2'b00,
    ACT_BUBBLE  = 2'b01,
    ACT_CAPTURE = 2'b10
  } act_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [RA_W-1:0]  REG_ZERO = {RA_W{1'b0}};

  ctrl_t            ctrl_in_s;
  ctrl_t            ctrl_nxt_s;
  ctrl_t            ctrl_r;
  data_t            data_in_s;
  data_t            data_nxt_s;
  data_t            data_r;
  logic             valid_nxt_s;
  logic             valid_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic             hazard_s;
  act_t             act_s;

  // Saturating increment for the bubble counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? CNT_MAX : (c + CNT_ONE);
  endfunction

  assign ctrl_in_s = '{reg_dst: reg_dst_i, branch: branch_i, mem_to_reg: mem_to_reg_i,
                       alu_src: alu_src_i, reg_write: reg_write_i, jump: jump_i,
                       mem_read: mem_read_i, mem_write: mem_write_i, alu_op: alu_op_i};

  assign data_in_s = '{pc4: pc4_i, rs_data: rs_data_i, rt_data: rt_data_i, imm: imm_i,
                       rs: rs_i, rt: rt_i, rd: rd_i, funct: funct_i};

`ifdef ID_EX_HAZARD_EN
  logic [RA_W-1:0] dest_ex_s;

  // Load-use check: a valid load in EX writes a register that decode reads.
  // Both rs and rt are compared, whatever the opcode in decode.
  always_comb begin
    dest_ex_s = ctrl_r.reg_dst ? data_r.rd : data_r.rt;
    hazard_s  = valid_r
              & (ctrl_r.mem_read != 2'b00)
              & ctrl_r.reg_write
              & valid_i
              & (dest_ex_s != REG_ZERO)
              & ((dest_ex_s == rs_i) | (dest_ex_s == rt_i));
  end
`else
  assign hazard_s = 1'b0;
`endif

  // A flush already squashes decode, so upstream is not asked to hold.
  assign hazard_stall_o = hazard_s & ~flush_i;

  // Select the update. Flush beats stall, and stall beats the load-use bubble.
  always_comb begin
    act_s = ACT_CAPTURE;
    if (flush_i) begin
      act_s = ACT_BUBBLE;
    end else if (stall_i) begin
      act_s = ACT_HOLD;
    end else if (hazard_s) begin
      act_s = ACT_BUBBLE;
    end else begin
      act_s = ACT_CAPTURE;
    end
  end

  // Compute the next register contents for the selected update.
  always_comb begin
    ctrl_nxt_s  = ctrl_r;
    data_nxt_s  = data_r;
    valid_nxt_s = valid_r;
    cnt_nxt_s   = cnt_r;
    case (act_s)
      ACT_HOLD: begin
        ctrl_nxt_s  = ctrl_r;
        data_nxt_s  = data_r;
        valid_nxt_s = valid_r;
        cnt_nxt_s   = cnt_r;
      end
      ACT_BUBBLE: begin
        ctrl_nxt_s  = '0;
        valid_nxt_s = 1'b0;
        cnt_nxt_s   = sat_inc(cnt_r);
      end
      ACT_CAPTURE: begin
        // An empty decode slot carries its data but no side effects.
        ctrl_nxt_s  = valid_i ? ctrl_in_s : ctrl_t'('0);
        data_nxt_s  = data_in_s;
        valid_nxt_s = valid_i;
      end
      default: begin
        ctrl_nxt_s  = '0;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_r  <= '0;
      data_r  <= '0;
      valid_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      ctrl_r  <= ctrl_nxt_s;
      data_r  <= data_nxt_s;
      valid_r <= valid_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign reg_dst_o    = ctrl_r.reg_dst;
  assign branch_o     = ctrl_r.branch;
  assign mem_to_reg_o = ctrl_r.mem_to_reg;
  assign alu_src_o    = ctrl_r.alu_src;
  assign reg_write_o  = ctrl_r.reg_write;
  assign jump_o       = ctrl_r.jump;
  assign mem_read_o   = ctrl_r.mem_read;
  assign mem_write_o  = ctrl_r.mem_write;
  assign alu_op_o     = ctrl_r.alu_op;
  assign pc4_o        = data_r.pc4;
  assign rs_data_o    = data_r.rs_data;
  assign rt_data_o    = data_r.rt_data;
  assign imm_o        = data_r.imm;
  assign rs_o         = data_r.rs;
  assign rt_o         = data_r.rt;
  assign rd_o         = data_r.rd;
  assign funct_o      = data_r.funct;
  assign valid_o      = valid_r;
  assign bubble_cnt_o = cnt_r;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the pipelined MIPS datapath. It captures the decoded control word from the control unit, plus the operands and register indices from the decode stage, and presents them to the execute stage one cycle later. It inserts bubbles on flush and on load-use hazards, holds on external stall, and counts inserted bubbles for performance monitoring.

## Interface
- DATA_W, 32, width of PC+4, register operands and sign-extended immediate
- RA_W, 5, register index width
- CNT_W, 16, bubble counter width
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- valid_i  in  1  the IF/ID slot holds a real instruction
- stall_i  in  1  external hold (memory not ready); freeze all state
- flush_i  in  1  branch/jump resolved taken; the instruction in decode is wrong-path
- reg_dst_i, branch_i, mem_to_reg_i, alu_src_i, reg_write_i  in  1 each  control bits from the control unit
- jump_i, mem_read_i, mem_write_i  in  2 each  control fields (mem 00=none, 01=word, 10=byte, 11=half)
- alu_op_i  in  4  ALU operation class
- pc4_i, rs_data_i, rt_data_i, imm_i  in  DATA_W each  decode-stage data
- rs_i, rt_i, rd_i  in  RA_W each  register indices
- funct_i  in  6  function field
- every input above from reg_dst_i to funct_i has a registered counterpart with suffix _o and the same width (out)
- valid_o  out  1  EX slot holds a real instruction
- hazard_stall_o  out  1  combinational; load-use hazard detected; PC and IF/ID must hold
- bubble_cnt_o  out  CNT_W  saturating count of inserted bubbles

## Operation
- Registered outputs update from one of four next-state sources. Priority, highest first: rst, flush_i, stall_i, hazard, capture.
- Bubble: valid_o=0 and every control _o=0 (mem_read, mem_write, jump, alu_op all zero; reg_write=0; branch=0). Data _o fields keep their previous values in a bubble.
- Capture: every _o takes its _i value, and valid_o takes valid_i. When valid_i=0, the control fields are zeroed as in a bubble.
- EX destination: dest_ex = reg_dst_o ? rd_o : rt_o.
- Hazard (combinational): valid_o & (mem_read_o!=0) & reg_write_o & valid_i & (dest_ex!=0) & (dest_ex==rs_i | dest_ex==rt_i). Both rs and rt are compared for every opcode (conservative).
- hazard_stall_o = hazard & ~flush_i. It is still asserted while stall_i=1.
- Hazard cycle: insert a bubble. Upstream holds, so the same instruction is re-presented the next cycle. The bubble clears mem_read_o, so hazard deasserts and the instruction is captured. Exactly one bubble is inserted per load-use.
- Flush cycle: insert a bubble regardless of hazard or stall.
- Stall cycle (no flush): all registers hold, including the counter.
- bubble_cnt_o increments by 1 on each hazard or flush bubble. It does not count stall cycles, reset, or capture with valid_i=0. It saturates at all-ones.

## Timing
- Latency: input sampled at edge N appears on _o after edge N; one cycle.
- Reset value: every _o is 0, valid_o=0, bubble_cnt_o=0. hazard_stall_o is therefore 0 during and after reset.
- Reset asserted mid-hazard or mid-stall: the next edge clears all state; no bubble is counted.
- flush_i and hazard in the same cycle: one bubble, counter +1, hazard_stall_o=0.
- stall_i and hazard in the same cycle: hold; hazard_stall_o=1; the bubble is inserted on the first unstalled edge.
- Counter at all-ones plus another bubble: stays at all-ones.
- No combinational path from any _i to any _o other than hazard_stall_o.

## Configuration
- ID_EX_HAZARD_EN defined: load-use detection is built as described.
- ID_EX_HAZARD_EN undefined: hazard is constant 0 and hazard_stall_o is tied 0. Only flush bubbles are inserted and counted. All other behaviour is unchanged.

## Test plan
- Reset: hold rst=1 for 2 cycles with random inputs -> all outputs 0, bubble_cnt_o=0.
- Capture: valid_i=1, add opcode controls (reg_write_i=1, alu_op_i=0000, rd_i=3), pc4_i=0x104 -> next cycle _o fields match, valid_o=1, counter unchanged.
- Load-use: lw in EX (mem_read_o=01, reg_dst_o=1, rd_o=8), decode rs_i=8 -> hazard_stall_o=1; next cycle valid_o=0 and all controls 0; following cycle the instruction is captured; bubble_cnt_o=1. With ID_EX_HAZARD_EN undefined -> hazard_stall_o=0 and no bubble.
- Load to $0: same as above with rd_o=0 -> no hazard.
- Flush vs stall: flush_i=1 together with stall_i=1 and a hazard -> bubble, hazard_stall_o=0, counter +1. Then stall_i=1 alone for 3 cycles -> outputs frozen.
- Saturation: preload with 0xFFFF flush bubbles (or use CNT_W=4 and 16 flushes), then one more flush -> bubble_cnt_o stays at all-ones.
